// File: rtl/sap_pkg.sv
// Shared definitions for the SAP core: opcode encodings, FSM state type and
// instruction field widths.
package sap_pkg;

   localparam int OPC_W = 4;

   localparam logic [OPC_W-1:0] OP_LDA = 4'h0;
   localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
   localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
   localparam logic [OPC_W-1:0] OP_STA = 4'h3;
   localparam logic [OPC_W-1:0] OP_LDI = 4'h4;
   localparam logic [OPC_W-1:0] OP_JMP = 4'h5;
   localparam logic [OPC_W-1:0] OP_JC  = 4'h6;
   localparam logic [OPC_W-1:0] OP_JZ  = 4'h7;
   localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
   localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_HALT
   } state_t;

   // Opcodes that need a second memory access in the MEM state.
   function automatic logic is_mem_op(input logic [OPC_W-1:0] op);
      return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/sap_if.sv
// Synchronous-read RAM bus between the SAP core (master) and its memory (slave).
interface sap_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;

   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_we,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_we,
      output mem_rdata
   );
endinterface

// File: rtl/sap_alu.sv
// Combinational add/subtract unit; carry doubles as no-borrow on subtract.
module sap_alu #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              sub,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              zero
);

   logic [DATA_W-1:0] b_eff;
   logic [DATA_W:0]   sum;

   // Two's-complement subtract: carry out of a + ~b + 1 is set exactly when a >= b.
   assign b_eff  = sub ? ~b : b;
   assign sum    = {1'b0, a} + {1'b0, b_eff} + (DATA_W+1)'(sub);
   assign result = sum[DATA_W-1:0];
   assign carry  = sum[DATA_W];
   assign zero   = (result == '0);

endmodule

// File: rtl/sap_core.sv
// Single-clock SAP core: registers, T-state FSM and ALU flag handling.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_FETCH  | present PC to RAM
//   S_DECODE | latch instruction into IR, advance PC
//   S_EXEC   | execute opcode; issue operand read/write, jumps, OUT, LDI
//   S_MEM    | consume operand read for LDA/ADD/SUB, update A and flags
//   S_HALT   | stopped until reset
module sap_core
   import sap_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   sap_if.master             bus,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              halted,
   output logic              flag_c,
   output logic              flag_z
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] ir_q;
   logic              c_q, z_q;
   logic [DATA_W-1:0] out_data_q;
   logic              out_valid_q;

   logic [OPC_W-1:0]  opcode;
   logic [ADDR_W-1:0] operand;
   logic [DATA_W-1:0] alu_result;
   logic              alu_carry;
   logic              alu_zero;

   assign opcode  = ir_q[DATA_W-1 -: OPC_W];
   assign operand = ir_q[ADDR_W-1:0];

   sap_alu #(.DATA_W(DATA_W)) u_alu (
      .a      (a_q),
      .b      (bus.mem_rdata),
      .sub    (opcode == OP_SUB),
      .result (alu_result),
      .carry  (alu_carry),
      .zero   (alu_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (is_mem_op(opcode))     state_d = S_MEM;
            else if (opcode == OP_HLT) state_d = S_HALT;
            else                       state_d = S_FETCH;
         end
         S_MEM:    state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   // Write strobe is gated by reset so an STA caught mid-EXEC never lands.
   always_comb begin
      bus.mem_addr = pc_q;
      bus.mem_we   = 1'b0;
      case (state_q)
         S_EXEC: begin
            if (is_mem_op(opcode) || (opcode == OP_STA)) bus.mem_addr = operand;
            if (opcode == OP_STA) bus.mem_we = ~reset;
         end
         S_MEM:   bus.mem_addr = operand;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= '0;
         a_q         <= '0;
         ir_q        <= '0;
         c_q         <= 1'b0;
         z_q         <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            S_DECODE: begin
               ir_q <= bus.mem_rdata;
               pc_q <= pc_q + ADDR_W'(1);
            end
            S_EXEC: begin
               case (opcode)
                  OP_LDI: a_q  <= DATA_W'(operand);
                  OP_JMP: pc_q <= operand;
                  OP_JC:  if (c_q) pc_q <= operand;
                  OP_JZ:  if (z_q) pc_q <= operand;
                  OP_OUT: begin
                     out_data_q  <= a_q;
                     out_valid_q <= 1'b1;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               case (opcode)
                  OP_LDA: a_q <= bus.mem_rdata;
                  OP_ADD, OP_SUB: begin
                     a_q <= alu_result;
                     c_q <= alu_carry;
                     z_q <= alu_zero;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_wdata = a_q;
   assign out_data      = out_data_q;
   assign out_valid     = out_valid_q;
   assign halted        = (state_q == S_HALT);
   assign flag_c        = c_q;
   assign flag_z        = z_q;

endmodule

// File: tb/tb_sap_core.sv
// Self-checking bench for sap_core: program-driven scenarios with a behavioural
// synchronous-read RAM and scoreboard queues for OUT values and RAM writes.
module tb_sap_core;

   logic       clk;
   logic       reset;
   logic [7:0] out_data;
   logic       out_valid;
   logic       halted;
   logic       flag_c;
   logic       flag_z;

   sap_if #(.DATA_W(8), .ADDR_W(4)) bus ();

   sap_core #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.master),
      .out_data  (out_data),
      .out_valid (out_valid),
      .halted    (halted),
      .flag_c    (flag_c),
      .flag_z    (flag_z)
   );

   logic [7:0]  ram  [16];
   logic [7:0]  prog [16];
   logic        load;
   logic [7:0]  out_q [$];
   logic [11:0] wr_q  [$];
   int          tests;
   int          fails;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 16; i++) ram[i] <= prog[i];
      end else if (bus.mem_we) begin
         ram[bus.mem_addr] <= bus.mem_wdata;
      end
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   task automatic clear_prog();
      for (int i = 0; i < 16; i++) prog[i] = 8'h80;
   endtask

   // Loads prog into RAM on the first reset edge; returns in cycle 1.
   task automatic start(input int n);
      reset = 1'b1;
      load  = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      for (int i = 1; i < n; i++) begin
         @(posedge clk); #1;
      end
      reset = 1'b0;
   endtask

   task automatic test_reset();
      clear_prog();
      prog[0] = 8'h09; prog[1] = 8'h1A; prog[2] = 8'h2B; prog[3] = 8'hE0; prog[4] = 8'hF0;
      prog[9] = 8'h1C; prog[10] = 8'h0E; prog[11] = 8'h03;
      reset = 1'b1;
      load  = 1'b1;
      #1;
      tests++;
      if (bus.mem_we !== 1'b0) begin
         fails++; $display("FAIL reset_we_comb: mem_we=%b expected 0", bus.mem_we);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         load = 1'b0;
         tests++;
         if (bus.mem_we !== 1'b0) begin
            fails++; $display("FAIL reset_we cycle %0d: mem_we=%b expected 0", i, bus.mem_we);
         end
         tests++;
         if ({out_data, out_valid, halted, flag_c, flag_z, bus.mem_wdata} !== 20'h0) begin
            fails++;
            $display("FAIL reset_outputs cycle %0d: out_data=%h out_valid=%b halted=%b c=%b z=%b a=%h expected all 0",
                     i, out_data, out_valid, halted, flag_c, flag_z, bus.mem_wdata);
         end
      end
      reset = 1'b0;
      tests++;
      if (bus.mem_addr !== 4'h0) begin
         fails++; $display("FAIL reset_first_addr: mem_addr=%h expected 0", bus.mem_addr);
      end
   endtask

   task automatic test_arith();
      clear_prog();
      prog[0] = 8'h09; prog[1] = 8'h1A; prog[2] = 8'h2B; prog[3] = 8'hE0; prog[4] = 8'hF0;
      prog[9] = 8'h1C; prog[10] = 8'h0E; prog[11] = 8'h03;
      out_q.push_back(8'h27);
      start(2);
      for (int k = 1; k <= 20; k++) begin
         if (out_valid === 1'b1 && out_q.size() > 0) begin
            logic [7:0] exp_v;
            exp_v = out_q.pop_front();
            tests++;
            if (out_data !== exp_v) begin
               fails++; $display("FAIL arith_out: out_data=%h expected %h", out_data, exp_v);
            end
         end
         tests++;
         if (out_valid !== (k == 16)) begin
            fails++; $display("FAIL arith_out_valid cycle %0d: got %b expected %b", k, out_valid, (k == 16));
         end
         tests++;
         if (halted !== (k >= 19)) begin
            fails++; $display("FAIL arith_halted cycle %0d: got %b expected %b", k, halted, (k >= 19));
         end
         @(posedge clk); #1;
      end
      tests++;
      if ({flag_c, flag_z} !== 2'b10 || bus.mem_wdata !== 8'h27) begin
         fails++; $display("FAIL arith_flags: c=%b z=%b a=%h expected c=1 z=0 a=27", flag_c, flag_z, bus.mem_wdata);
      end
      tests++;
      if (out_q.size() != 0) begin
         fails++; $display("FAIL arith_scoreboard: %0d outputs missing expected 0", out_q.size());
         out_q.delete();
      end
   endtask

   task automatic test_carry_jc();
      clear_prog();
      prog[0] = 8'h0E; prog[1] = 8'h1F; prog[2] = 8'h68; prog[8] = 8'hE0; prog[9] = 8'hF0;
      prog[14] = 8'hFF; prog[15] = 8'h01;
      out_q.push_back(8'h00);
      start(2);
      for (int k = 1; k <= 18; k++) begin
         if (k == 9) begin
            tests++;
            if (bus.mem_wdata !== 8'h00 || flag_c !== 1'b1 || flag_z !== 1'b1) begin
               fails++; $display("FAIL carry_flags: a=%h c=%b z=%b expected a=00 c=1 z=1", bus.mem_wdata, flag_c, flag_z);
            end
         end
         if (k == 12) begin
            tests++;
            if (bus.mem_addr !== 4'h8) begin
               fails++; $display("FAIL jc_target: mem_addr=%h expected 8", bus.mem_addr);
            end
         end
         if (out_valid === 1'b1 && out_q.size() > 0) begin
            logic [7:0] exp_v;
            exp_v = out_q.pop_front();
            tests++;
            if (out_data !== exp_v) begin
               fails++; $display("FAIL jc_out: out_data=%h expected %h", out_data, exp_v);
            end
         end
         tests++;
         if (out_valid !== (k == 15)) begin
            fails++; $display("FAIL jc_out_valid cycle %0d: got %b expected %b", k, out_valid, (k == 15));
         end
         @(posedge clk); #1;
      end
      tests++;
      if (halted !== 1'b1 || out_q.size() != 0) begin
         fails++; $display("FAIL jc_end: halted=%b pending=%0d expected halted=1 pending=0", halted, out_q.size());
         out_q.delete();
      end
   endtask

   task automatic test_borrow_jz();
      clear_prog();
      prog[0] = 8'h42; prog[1] = 8'h2E; prog[2] = 8'h70; prog[3] = 8'hE0; prog[4] = 8'hF0;
      prog[14] = 8'h05;
      out_q.push_back(8'hFD);
      start(2);
      for (int k = 1; k <= 14; k++) begin
         if (k == 8) begin
            tests++;
            if (bus.mem_wdata !== 8'hFD || flag_c !== 1'b0 || flag_z !== 1'b0) begin
               fails++; $display("FAIL borrow_flags: a=%h c=%b z=%b expected a=fd c=0 z=0", bus.mem_wdata, flag_c, flag_z);
            end
         end
         if (k == 11) begin
            tests++;
            if (bus.mem_addr !== 4'h3) begin
               fails++; $display("FAIL jz_not_taken: mem_addr=%h expected 3", bus.mem_addr);
            end
         end
         if (out_valid === 1'b1 && out_q.size() > 0) begin
            logic [7:0] exp_v;
            exp_v = out_q.pop_front();
            tests++;
            if (out_data !== exp_v) begin
               fails++; $display("FAIL borrow_out: out_data=%h expected %h", out_data, exp_v);
            end
         end
         @(posedge clk); #1;
      end
      tests++;
      if (out_q.size() != 0) begin
         fails++; $display("FAIL borrow_scoreboard: %0d outputs missing expected 0", out_q.size());
         out_q.delete();
      end
   endtask

   task automatic test_store_wrap();
      int we_count;
      clear_prog();
      prog[0] = 8'h47; prog[1] = 8'h3E; prog[2] = 8'h0E; prog[3] = 8'h5F; prog[15] = 8'h80;
      prog[14] = 8'h00;
      wr_q.push_back({4'hE, 8'h07});
      we_count = 0;
      start(2);
      for (int k = 1; k <= 17; k++) begin
         if (bus.mem_we === 1'b1) begin
            logic [11:0] exp_w;
            we_count++;
            exp_w = (wr_q.size() > 0) ? wr_q.pop_front() : 12'hxxx;
            tests++;
            if ({bus.mem_addr, bus.mem_wdata} !== exp_w) begin
               fails++; $display("FAIL sta_write cycle %0d: addr=%h data=%h expected %h", k, bus.mem_addr, bus.mem_wdata, exp_w);
            end
         end
         if (k == 11) begin
            tests++;
            if (bus.mem_wdata !== 8'h07) begin
               fails++; $display("FAIL lda_reload: a=%h expected 07", bus.mem_wdata);
            end
         end
         if (k == 14) begin
            tests++;
            if (bus.mem_addr !== 4'hF) begin
               fails++; $display("FAIL jmp_to_f: mem_addr=%h expected f", bus.mem_addr);
            end
         end
         if (k == 17) begin
            tests++;
            if (bus.mem_addr !== 4'h0) begin
               fails++; $display("FAIL pc_wrap: mem_addr=%h expected 0", bus.mem_addr);
            end
         end
         @(posedge clk); #1;
      end
      tests++;
      if (we_count != 1 || wr_q.size() != 0 || ram[14] !== 8'h07) begin
         fails++; $display("FAIL sta_summary: we_count=%0d pending=%0d ram_e=%h expected 1 0 07", we_count, wr_q.size(), ram[14]);
         wr_q.delete();
      end
   endtask

   task automatic test_reset_during_sta();
      clear_prog();
      prog[0] = 8'h49; prog[1] = 8'h3E; prog[14] = 8'h55;
      start(2);
      for (int k = 1; k < 6; k++) begin
         @(posedge clk); #1;
      end
      tests++;
      if (bus.mem_we !== 1'b1) begin
         fails++; $display("FAIL sta_exec_setup: mem_we=%b expected 1", bus.mem_we);
      end
      reset = 1'b1;
      #1;
      tests++;
      if (bus.mem_we !== 1'b0) begin
         fails++; $display("FAIL reset_sta_we: mem_we=%b expected 0", bus.mem_we);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      tests++;
      if (bus.mem_addr !== 4'h0) begin
         fails++; $display("FAIL reset_sta_addr: mem_addr=%h expected 0", bus.mem_addr);
      end
      tests++;
      if (ram[14] !== 8'h55 || bus.mem_wdata !== 8'h00) begin
         fails++; $display("FAIL reset_sta_ram: ram_e=%h a=%h expected 55 00", ram[14], bus.mem_wdata);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      load  = 1'b0;
      clear_prog();
      test_reset();
      test_arith();
      test_reset();
      test_carry_jc();
      test_borrow_jz();
      test_store_wrap();
      test_reset_during_sta();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
